mode_counter: RTL and testbench
===============================

MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of count, limit, load_value; legal range 2..32.
REQ-002 SHALL have parameter RESET_VALUE, default 0: count value on reset; must fit WIDTH bits.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  advance one step on this clock edge.
REQ-006 SHALL have port load  input  1  synchronous load strobe.
REQ-007 SHALL have port load_value  input  WIDTH  value captured on load.
REQ-008 SHALL have port limit  input  WIDTH  inclusive upper bound; count range is 0..limit.
REQ-009 SHALL have port mode  input  2  00 up-wrap, 01 down-wrap, 10 ping-pong, 11 one-shot up.
REQ-010 SHALL have port count  output  WIDTH  registered count.
REQ-011 SHALL have port dir  output  1  registered direction: 0 up, 1 down; meaningful in ping-pong only.
REQ-012 SHALL have port tc  output  1  registered one-cycle terminal-count pulse.
REQ-013 SHALL have port done  output  1  registered one-shot completion flag.

Function
REQ-014 SHALL give load priority over enable; when load=1 the enable input is ignored for that cycle.
REQ-015 SHALL on load set count to min(load_value, limit), dir to 0, done to 0, tc to 0.
REQ-016 SHALL hold count, dir and done, and drive tc=0, when load=0 and enable=0; count is never high-impedance.
REQ-017 SHALL in mode 00 on enabled step: count>=limit -> count=0 and tc=1; otherwise count+1 and tc=0.
REQ-018 SHALL in mode 01 on enabled step: count=0 -> count=limit and tc=1; count>limit -> count=limit and tc=0; otherwise count-1 and tc=0.
REQ-019 SHALL in mode 10 with dir=0 on enabled step: count>=limit -> count=limit-1, dir=1, tc=1; otherwise count+1.
REQ-020 SHALL in mode 10 with dir=1 on enabled step: count=0 -> count=1, dir=0, tc=1; count>limit -> count=limit; otherwise count-1.
REQ-021 SHALL in mode 11 on enabled step with done=0: count+1; if the new count equals limit, or count was already >=limit (then count=limit), set done=1 and tc=1.
REQ-022 SHALL in mode 11 with done=1 hold count and keep tc=0 on enabled steps until load or reset.
REQ-023 SHALL when limit=0 force count to 0 on every enabled step in every mode, with tc=1 on each such step (done=1 in mode 11 after the first step).
REQ-024 SHALL apply mode and limit changes on the next enabled step with no pipeline delay; dir and done are not cleared by a mode change.
REQ-025 SHALL compute all arithmetic modulo 2^WIDTH with no carry-out port; limit=2^WIDTH-1 is a full-range counter.
REQ-026 SHALL assert tc for exactly one clock after the qualifying step; back-to-back qualifying steps produce consecutive tc cycles.

Reset
REQ-027 SHALL on reset=1, asynchronously and independent of clk, set count=RESET_VALUE, dir=0, tc=0, done=0.
REQ-028 SHALL ignore load and enable while reset=1; the first step after deassertion occurs on the first rising clk edge with reset=0.
REQ-029 SHALL not clamp RESET_VALUE to limit; an out-of-range count resolves per REQ-017..REQ-021 on the next step.

Verification
REQ-030 SHALL cover mode 00, limit=5, from reset, enable high 7 cycles -> count 1,2,3,4,5,0,1; tc high only on cycle following 5->0.
REQ-031 SHALL cover mode 10, limit=3, from 0 -> count 1,2,3,2,1,0,1; dir 0,0,0,1,1,1,0; tc after 3->2 and 0->1.
REQ-032 SHALL cover mode 11, limit=4, load_value=2 -> count 3,4 then held at 4; done=1 and single tc; second load clears done.
REQ-033 SHALL cover load=1 and enable=1 together with load_value=200, limit=100 -> count=100, no step taken.
REQ-034 SHALL cover reset asserted mid-count between clock edges at count=0x37 -> count=RESET_VALUE immediately, tc=0, done=0, dir=0.
REQ-035 SHALL cover WIDTH=8, limit=255, mode 01 from 0 -> count 255, tc=1; then limit=0 -> count 0 with tc every enabled cycle.

Source files
------------

// File: rtl/mode_counter.sv
// mode_counter: multi-mode bounded counter.
//   mode 00 up-wrap, 01 down-wrap, 10 ping-pong, 11 one-shot up.
// The count range is 0..limit inclusive. Loading clamps the value to the limit.
// tc is a registered one-cycle pulse that follows each qualifying step.
// done is the registered completion flag for one-shot mode.
module mode_counter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    MODE_UP_WRAP   = 2'b00,
    MODE_DOWN_WRAP = 2'b01,
    MODE_PING_PONG = 2'b10,
    MODE_ONE_SHOT  = 2'b11
  } mode_e;

  // Reset value is deliberately not clamped to limit; an out-of-range
  // count settles through the normal step rules.
  localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  // Architectural state
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             dir_reg;
  logic             dir_next;
  logic             tc_reg;
  logic             tc_next;
  logic             done_reg;
  logic             done_next;

  // Decoded mode and shared arithmetic
  mode_e            mode_sel;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_dec;
  logic [WIDTH-1:0] limit_dec;
  logic [WIDTH-1:0] load_clamped;
  logic             count_at_or_above;
  logic             count_above;
  logic             count_zero;
  logic             limit_zero;

  assign mode_sel = mode_e'(mode);

  // Shared arithmetic and compares. All arithmetic wraps at 2^WIDTH.
  // No carry leaves the block.
  assign count_inc         = count_reg + ONE;
  assign count_dec         = count_reg - ONE;
  assign limit_dec         = limit - ONE;
  assign count_at_or_above = (count_reg >= limit);
  assign count_above       = (count_reg > limit);
  assign count_zero        = (count_reg == '0);
  assign limit_zero        = (limit == '0);
  assign load_clamped      = (load_value > limit) ? limit : load_value;

  // Next-state selection.
  // Load takes priority over enable, and limit=0 overrides every mode.
  always_comb begin
    count_next = count_reg;
    dir_next   = dir_reg;
    done_next  = done_reg;
    tc_next    = 1'b0;

    if (load) begin
      count_next = load_clamped;
      dir_next   = 1'b0;
      done_next  = 1'b0;
    end else if (enable) begin
      if (limit_zero) begin
        // Degenerate range: the counter sits at zero and every step is terminal.
        count_next = '0;
        tc_next    = 1'b1;
        if (mode_sel == MODE_ONE_SHOT) begin
          done_next = 1'b1;
        end
      end else begin
        case (mode_sel)
          MODE_UP_WRAP: begin
            if (count_at_or_above) begin
              count_next = '0;
              tc_next    = 1'b1;
            end else begin
              count_next = count_inc;
            end
          end

          MODE_DOWN_WRAP: begin
            if (count_zero) begin
              count_next = limit;
              tc_next    = 1'b1;
            end else if (count_above) begin
              count_next = limit;
            end else begin
              count_next = count_dec;
            end
          end

          MODE_PING_PONG: begin
            if (!dir_reg) begin
              if (count_at_or_above) begin
                // Turn around at the top. The top value is not repeated.
                count_next = limit_dec;
                dir_next   = 1'b1;
                tc_next    = 1'b1;
              end else begin
                count_next = count_inc;
              end
            end else begin
              if (count_zero) begin
                // Turn around at the bottom. Zero is not repeated.
                count_next = ONE;
                dir_next   = 1'b0;
                tc_next    = 1'b1;
              end else if (count_above) begin
                count_next = limit;
              end else begin
                count_next = count_dec;
              end
            end
          end

          MODE_ONE_SHOT: begin
            if (!done_reg) begin
              if (count_at_or_above) begin
                count_next = limit;
                done_next  = 1'b1;
                tc_next    = 1'b1;
              end else begin
                // count < limit here, so the increment cannot wrap.
                count_next = count_inc;
                if (count_inc == limit) begin
                  done_next = 1'b1;
                  tc_next   = 1'b1;
                end
              end
            end
          end

          default: begin
            count_next = count_reg;
          end
        endcase
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= RESET_COUNT;
      dir_reg   <= 1'b0;
      tc_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      dir_reg   <= dir_next;
      tc_reg    <= tc_next;
      done_reg  <= done_next;
    end
  end

  assign count = count_reg;
  assign dir   = dir_reg;
  assign tc    = tc_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_mode_counter.sv
// Directed testbench for mode_counter (WIDTH=8, RESET_VALUE=0).
module tb_mode_counter;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] limit;
  logic [1:0]       mode;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             tc;
  logic             done;

  int checks = 0;
  int errors = 0;

  mode_counter #(.WIDTH(WIDTH), .RESET_VALUE(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .limit      (limit),
    .mode       (mode),
    .count      (count),
    .dir        (dir),
    .tc         (tc),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check all four outputs against the expected values.
  task automatic check_all(input string tag, input int exp_count, input int exp_dir,
                           input int exp_tc, input int exp_done);
    check({tag, ".count"}, 32'(count), 32'(exp_count));
    check({tag, ".dir"},   32'(dir),   32'(exp_dir));
    check({tag, ".tc"},    32'(tc),    32'(exp_tc));
    check({tag, ".done"},  32'(done),  32'(exp_done));
    $display("step %s: count=%0d dir=%0d tc=%0d done=%0d", tag, count, dir, tc, done);
  endtask

  // Advance one clock edge, then wait 1 time unit before sampling the outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Watchdog timer: the bench ends even if the directed sequence stalls.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0;
    load_value = '0; limit = 8'd5; mode = 2'b00;
    #2;
    check_all("reset", 0, 0, 0, 0);
    step();
    reset = 1'b0;

    // Up-wrap, limit 5, 7 enabled steps: count 1,2,3,4,5,0,1.
    // tc goes high only on the step after the 5->0 wrap.
    enable = 1'b1;
    step(); check_all("up1", 1, 0, 0, 0);
    step(); check_all("up2", 2, 0, 0, 0);
    step(); check_all("up3", 3, 0, 0, 0);
    step(); check_all("up4", 4, 0, 0, 0);
    step(); check_all("up5", 5, 0, 0, 0);
    step(); check_all("up6", 0, 0, 1, 0);
    step(); check_all("up7", 1, 0, 0, 0);
    enable = 1'b0;
    step(); check_all("hold", 1, 0, 0, 0);

    // Ping-pong, limit 3, starting from 0.
    load = 1'b1; load_value = 8'd0; mode = 2'b10; limit = 8'd3;
    step(); check_all("pp_load", 0, 0, 0, 0);
    load = 1'b0; enable = 1'b1;
    step(); check_all("pp1", 1, 0, 0, 0);
    step(); check_all("pp2", 2, 0, 0, 0);
    step(); check_all("pp3", 3, 0, 0, 0);
    step(); check_all("pp4", 2, 1, 1, 0);
    step(); check_all("pp5", 1, 1, 0, 0);
    step(); check_all("pp6", 0, 1, 0, 0);
    step(); check_all("pp7", 1, 0, 1, 0);

    // One-shot, limit 4, loaded with 2.
    enable = 1'b0; load = 1'b1; load_value = 8'd2; mode = 2'b11; limit = 8'd4;
    step(); check_all("os_load", 2, 0, 0, 0);
    load = 1'b0; enable = 1'b1;
    step(); check_all("os1", 3, 0, 0, 0);
    step(); check_all("os2", 4, 0, 1, 1);
    step(); check_all("os3", 4, 0, 0, 1);
    step(); check_all("os4", 4, 0, 0, 1);
    enable = 1'b0; load = 1'b1;
    step(); check_all("os_reload", 2, 0, 0, 0);

    // load and enable together: the load value is clamped and no step is taken.
    load = 1'b1; enable = 1'b1; load_value = 8'd200; limit = 8'd100; mode = 2'b00;
    step(); check_all("ld_pri", 100, 0, 0, 0);
    // Down-wrap from above the limit: snap to the limit with no tc, then count down.
    load = 1'b0; mode = 2'b01; limit = 8'd50;
    step(); check_all("dn_snap", 50, 0, 0, 0);
    step(); check_all("dn_dec", 49, 0, 0, 0);

    // Reach count=0x37 with dir=1 and tc=1, then reset between clock edges.
    enable = 1'b0; load = 1'b1; load_value = 8'h37; mode = 2'b10; limit = 8'h38;
    step(); check_all("pre_load", 8'h37, 0, 0, 0);
    load = 1'b0; enable = 1'b1;
    step(); check_all("pre_up", 8'h38, 0, 0, 0);
    step(); check_all("pre_turn", 8'h37, 1, 1, 0);
    enable = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0);
    // load and enable are ignored while reset is held.
    enable = 1'b1; load = 1'b1; load_value = 8'd9;
    step(); check_all("rst_hold", 0, 0, 0, 0);
    #2;
    reset = 1'b0; load = 1'b0; mode = 2'b00; limit = 8'd255;
    step(); check_all("rst_rel", 1, 0, 0, 0);

    // Full range: down-wrap from 0 gives 255 with tc. Then limit=0 gives tc on every step.
    enable = 1'b0; load = 1'b1; load_value = 8'd0; mode = 2'b01;
    step(); check_all("fr_load", 0, 0, 0, 0);
    load = 1'b0; enable = 1'b1;
    step(); check_all("fr_wrap", 255, 0, 1, 0);
    limit = 8'd0;
    step(); check_all("lz1", 0, 0, 1, 0);
    step(); check_all("lz2", 0, 0, 1, 0);
    step(); check_all("lz3", 0, 0, 1, 0);
    // limit=0 in one-shot mode: done is set after the first step.
    mode = 2'b11;
    step(); check_all("lz_os", 0, 0, 1, 1);
    // Full-range up-wrap: 254 -> 255 -> 0.
    enable = 1'b0; load = 1'b1; load_value = 8'd254; limit = 8'd255; mode = 2'b00;
    step(); check_all("fu_load", 254, 0, 0, 0);
    load = 1'b0; enable = 1'b1;
    step(); check_all("fu1", 255, 0, 0, 0);
    step(); check_all("fu2", 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
